// File: rtl/seq_mac_if.sv
// Bundle of request/response signals for the sequential MAC multiply stage.
//
// Handshake: the master raises start with operands and modes valid; the
// slave samples them only when not busy (IDLE or DONE). busy is high for the
// N computation cycles; done pulses for exactly one cycle when product (and
// acc, if accumulating) carry the new result. start seen while busy is
// ignored, and a start present during the done cycle begins the next
// operation immediately. clr_acc is honoured on any clock edge.
interface seq_mac_if #(
   parameter int M     = 4,
   parameter int N     = 3,
   parameter int ACC_W = M + N + 4
);
   logic             start;
   logic             signed_mode;
   logic             acc_en;
   logic             clr_acc;
   logic [M-1:0]     num1;
   logic [N-1:0]     num2;
   logic             busy;
   logic             done;
   logic [M+N-1:0]   product;
   logic [ACC_W-1:0] acc;
   logic             overflow;

   modport master (
      output start, signed_mode, acc_en, clr_acc, num1, num2,
      input  busy, done, product, acc, overflow
   );

   modport slave (
      input  start, signed_mode, acc_en, clr_acc, num1, num2,
      output busy, done, product, acc, overflow
   );
endinterface

// File: rtl/seq_mac_multiplier.sv
// Sequential shift-add M x N multiplier with sign handling and an
// accumulator that has sticky overflow. One partial product per clock;
// operands are converted to magnitudes at start and the sign is applied
// once at the end.
module seq_mac_multiplier #(
   parameter int M     = 4,
   parameter int N     = 3,
   parameter int ACC_W = M + N + 4
) (
   input  logic       clk,
   input  logic       rst_n,
   seq_mac_if.slave   bus,
   output logic [1:0] dbg_state
);
   localparam int PW = M + N;
   localparam int IW = $clog2(N + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [PW-1:0]    mcand_q, mcand_d;     // |num1|, shifted left each RUN cycle
   logic [N-1:0]     mplier_q, mplier_d;   // |num2|, shifted right each RUN cycle
   logic [PW-1:0]    partial_q, partial_d;
   logic             sign_q, sign_d;
   logic             smode_q, smode_d;
   logic             acc_en_q, acc_en_d;
   logic [PW-1:0]    product_q, product_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [M-1:0]     mag1;
   logic [N-1:0]     mag2;
   logic             sign_in;
   logic             last;
   logic [PW-1:0]    partial_sum;
   logic [PW-1:0]    prod_new;
   logic [ACC_W-1:0] ext;
   logic [ACC_W-1:0] acc_base;
   logic             ovf_base;
   logic [ACC_W:0]   sum;
   logic             new_ovf;

   // Next-state, datapath and accumulator update for one clock.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      partial_d = partial_q;
      sign_d    = sign_q;
      smode_d   = smode_q;
      acc_en_d  = acc_en_q;
      product_d = product_q;
      acc_d     = acc_q;
      ovf_d     = ovf_q;

      // Operand magnitudes and result sign as they would be latched now;
      // the most negative value negates to itself, which reads correctly
      // as an unsigned magnitude.
      mag1    = bus.num1;
      mag2    = bus.num2;
      sign_in = 1'b0;
      if (bus.signed_mode) begin
         if (bus.num1[M-1]) mag1 = ~bus.num1 + M'(1);
         if (bus.num2[N-1]) mag2 = ~bus.num2 + N'(1);
         sign_in = bus.num1[M-1] ^ bus.num2[N-1];
      end

      last        = (state_q == S_RUN) && (idx_q == IW'(N - 1));
      partial_sum = partial_q + (mplier_q[0] ? mcand_q : '0);
      prod_new    = sign_q ? (~partial_sum + PW'(1)) : partial_sum;

      // Extend the finished product to accumulator width per its mode.
      ext = ACC_W'(prod_new);
      if (smode_q && prod_new[PW-1]) ext = ext | ~(ACC_W'({PW{1'b1}}));

      // Clear takes effect before a coincident add.
      acc_base = bus.clr_acc ? '0 : acc_q;
      ovf_base = bus.clr_acc ? 1'b0 : ovf_q;
      sum      = {1'b0, acc_base} + {1'b0, ext};
      if (smode_q)
         new_ovf = (acc_base[ACC_W-1] == ext[ACC_W-1]) &&
                   (sum[ACC_W-1] != acc_base[ACC_W-1]);
      else
         new_ovf = sum[ACC_W];

      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d   = S_RUN;
               idx_d     = '0;
               mcand_d   = PW'(mag1);
               mplier_d  = mag2;
               partial_d = '0;
               sign_d    = sign_in;
               smode_d   = bus.signed_mode;
               acc_en_d  = bus.acc_en;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            partial_d = partial_sum;
            mcand_d   = mcand_q << 1;
            mplier_d  = mplier_q >> 1;
            idx_d     = idx_q + IW'(1);
            if (last) begin
               state_d   = S_DONE;
               product_d = prod_new;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (last && acc_en_q) begin
         acc_d = sum[ACC_W-1:0];
         ovf_d = ovf_base | new_ovf;
      end else if (bus.clr_acc) begin
         acc_d = '0;
         ovf_d = 1'b0;
      end

      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   // All state and registered outputs; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         partial_q <= '0;
         sign_q    <= 1'b0;
         smode_q   <= 1'b0;
         acc_en_q  <= 1'b0;
         product_q <= '0;
         acc_q     <= '0;
         ovf_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         partial_q <= partial_d;
         sign_q    <= sign_d;
         smode_q   <= smode_d;
         acc_en_q  <= acc_en_d;
         product_q <= product_d;
         acc_q     <= acc_d;
         ovf_q     <= ovf_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.product  = product_q;
   assign bus.acc      = acc_q;
   assign bus.overflow = ovf_q;
   assign dbg_state    = state_q;
endmodule

// File: tb/tb_seq_mac_multiplier.sv
// Bench for seq_mac_multiplier: directed cases plus random operations,
// checked by a scoreboard fed from an arithmetic reference model.
module tb_seq_mac_multiplier;
   localparam int M     = 4;
   localparam int N     = 3;
   localparam int ACC_W = 11;
   localparam int PW    = M + N;
   localparam int EW    = PW + ACC_W + 1;

   logic       clk;
   logic       rst_n;
   logic [1:0] dbg_state;

   seq_mac_if #(.M(M), .N(N), .ACC_W(ACC_W)) bus_if ();

   seq_mac_multiplier #(.M(M), .N(N), .ACC_W(ACC_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus_if.slave),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_q[$];   // {product, acc, overflow}
   int            n_checks = 0;
   int            n_pass   = 0;
   longint        model_acc = 0;
   bit            model_ovf = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   // Reference: true integer product and accumulator arithmetic.
   task automatic push_expected(input logic [M-1:0] a, input logic [N-1:0] b,
                                input logic sm, input logic ae, input logic clr);
      longint va, vb, p, pm, base, s, modp, moda, half;
      bit     o;
      modp = longint'(1) << PW;
      moda = longint'(1) << ACC_W;
      half = longint'(1) << (ACC_W - 1);
      va = longint'(a);
      vb = longint'(b);
      if (sm && a[M-1]) va = va - (longint'(1) << M);
      if (sm && b[N-1]) vb = vb - (longint'(1) << N);
      p  = va * vb;
      pm = ((p % modp) + modp) % modp;
      if (ae) begin
         base = clr ? 0 : model_acc;
         if (clr) model_ovf = 1'b0;
         if (sm) begin
            if (base >= half) base = base - moda;
            s = base + p;
            o = (s < -half) || (s > half - 1);
         end else begin
            s = base + p;
            o = (s >= moda);
         end
         model_acc = ((s % moda) + moda) % moda;
         model_ovf = model_ovf | o;
      end else if (clr) begin
         model_acc = 0;
         model_ovf = 1'b0;
      end
      exp_q.push_back({pm[PW-1:0], model_acc[ACC_W-1:0], model_ovf});
   endtask

   // Monitor: every done pulse is matched against the oldest expectation.
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (rst_n === 1'b1 && bus_if.done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 64'(bus_if.done), 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("product",  64'(bus_if.product),  64'(e[EW-1 -: PW]));
            check("acc",      64'(bus_if.acc),      64'(e[ACC_W:1]));
            check("overflow", 64'(bus_if.overflow), 64'(e[0]));
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at a negedge; returns at the negedge of the done cycle so a
   // following call restarts back-to-back.
   task automatic do_op(input logic [M-1:0] a, input logic [N-1:0] b,
                        input logic sm, input logic ae, input logic clr_end);
      bus_if.start       = 1'b1;
      bus_if.num1        = a;
      bus_if.num2        = b;
      bus_if.signed_mode = sm;
      bus_if.acc_en      = ae;
      bus_if.clr_acc     = 1'b0;
      push_expected(a, b, sm, ae, clr_end);
      for (int k = 0; k < N; k++) begin
         @(posedge clk);
         @(negedge clk);
         check("busy_in_run", 64'(bus_if.busy), 64'd1);
         // Inputs are don't-care while running; a stray start must be ignored.
         bus_if.start       = 1'($urandom_range(0, 1));
         bus_if.num1        = M'($urandom);
         bus_if.num2        = N'($urandom);
         bus_if.signed_mode = 1'($urandom_range(0, 1));
         bus_if.acc_en      = 1'($urandom_range(0, 1));
         if (k == N - 1) bus_if.clr_acc = clr_end;
      end
      @(posedge clk);
      @(negedge clk);
      check("done_latency", 64'(bus_if.done), 64'd1);
      check("busy_in_done", 64'(bus_if.busy), 64'd0);
      bus_if.start   = 1'b0;
      bus_if.clr_acc = 1'b0;
   endtask

   task automatic idle(input int n);
      bus_if.start = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic clr_pulse();
      bus_if.clr_acc = 1'b1;
      @(negedge clk);
      bus_if.clr_acc = 1'b0;
      model_acc = 0;
      model_ovf = 1'b0;
      check("clr_acc_acc", 64'(bus_if.acc), 64'd0);
      check("clr_acc_ovf", 64'(bus_if.overflow), 64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},     64'(bus_if.busy),     64'd0);
      check({tag, "_done"},     64'(bus_if.done),     64'd0);
      check({tag, "_product"},  64'(bus_if.product),  64'd0);
      check({tag, "_acc"},      64'(bus_if.acc),      64'd0);
      check({tag, "_overflow"}, 64'(bus_if.overflow), 64'd0);
      check({tag, "_state"},    64'(dbg_state),       64'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst_n              = 1'b0;
      bus_if.start       = 1'b0;
      bus_if.signed_mode = 1'b0;
      bus_if.acc_en      = 1'b0;
      bus_if.clr_acc     = 1'b0;
      bus_if.num1        = '0;
      bus_if.num2        = '0;
      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed products.
      do_op(4'hF, 3'h7, 1'b0, 1'b0, 1'b0);
      check("uns_15x7", 64'(bus_if.product), 64'h69);
      idle(1);
      do_op(4'h8, 3'h4, 1'b1, 1'b0, 1'b0);
      check("sgn_m8xm4", 64'(bus_if.product), 64'h20);
      do_op(4'h7, 3'h4, 1'b1, 1'b0, 1'b0);
      check("sgn_7xm4", 64'(bus_if.product), 64'h64);
      idle(2);

      // Twenty back-to-back unsigned accumulates of 105.
      for (int i = 1; i <= 20; i++) begin
         do_op(4'hF, 3'h7, 1'b0, 1'b1, 1'b0);
         if (i == 19) begin
            check("acc_after_19", 64'(bus_if.acc), 64'd1995);
            check("ovf_after_19", 64'(bus_if.overflow), 64'd0);
         end
      end
      check("acc_after_20", 64'(bus_if.acc), 64'd52);
      check("ovf_after_20", 64'(bus_if.overflow), 64'd1);
      idle(1);
      clr_pulse();

      // Build acc = 500, then clear coincident with an accumulate of 105.
      for (int i = 0; i < 4; i++) do_op(4'hF, 3'h7, 1'b0, 1'b1, 1'b0);
      do_op(4'hE, 3'h5, 1'b0, 1'b1, 1'b0);
      do_op(4'h5, 3'h2, 1'b0, 1'b1, 1'b0);
      check("acc_500", 64'(bus_if.acc), 64'd500);
      do_op(4'hF, 3'h7, 1'b0, 1'b1, 1'b1);
      check("clr_with_acc_acc", 64'(bus_if.acc), 64'd105);
      check("clr_with_acc_ovf", 64'(bus_if.overflow), 64'd0);
      idle(1);

      // Random operations with occasional gaps and coincident clears.
      for (int i = 0; i < 60; i++) begin
         do_op(M'($urandom), N'($urandom), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end

      // Reset during RUN cycle 2: no done, everything back to zero.
      bus_if.start       = 1'b1;
      bus_if.num1        = 4'hF;
      bus_if.num2        = 3'h7;
      bus_if.signed_mode = 1'b0;
      bus_if.acc_en      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_if.start = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrun_reset");
      model_acc = 0;
      model_ovf = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(4);
      check("no_done_after_reset", 64'(bus_if.done), 64'd0);
      do_op(4'h7, 3'h4, 1'b1, 1'b1, 1'b0);
      check("post_reset_product", 64'(bus_if.product), 64'h64);
      idle(2);

      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
